// File: rtl/enet_chclk_pkg.sv
// rtl/enet_chclk_pkg.sv - shared state encoding, defaults and helpers for the ENET clock-switch controller
//
// Contents:
//   chclk_state_t  FSM state encoding (IDLE/OFF/ON/DONE)
//   DEF_SYNC_LV    default depth of the clk_ena feedback synchronizer
//   DEF_TO_MAX     default per-phase wait limit (used when ENET_CHCLK_CTRL_TIMEOUT_EN is defined)
//   MAX_SRC        largest supported number of clock sources
//   onehot()       index -> one-hot mask, zero for out-of-range indices
package enet_chclk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OFF  = 2'd1,
    ST_ON   = 2'd2,
    ST_DONE = 2'd3
  } chclk_state_t;

  localparam int          DEF_SYNC_LV = 2;
  localparam logic [15:0] DEF_TO_MAX  = 16'hFFFF;
  localparam int          MAX_SRC     = 8;

  // Shifting a single set bit out of range yields zero, so an illegal
  // index can never produce a multi-hot mask.
  function automatic logic [MAX_SRC-1:0] onehot(input int unsigned idx);
    return {{(MAX_SRC-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/enet_chclk_ctrl_fsm.sv
// rtl/enet_chclk_ctrl_fsm.sv - break-before-make sequencer for the ENET clock-source select lines
//
// Optional feature macro: ENET_CHCLK_CTRL_TIMEOUT_EN (per-phase wait limit of TO_MAX cycles)
//
// Ports:
//   clk, rst_n  control clock, asynchronous active-low reset
//   req_valid   switch request; req_sel is the requested source index
//   req_ready   high only in IDLE
//   ack         synchronized clk_ena feedback, one bit per source
//   clk_sel     one-hot (or zero) select to each gating path
//   busy        sequencer not in IDLE
//   done / err  one-cycle completion / failure pulses
//   cur_sel     active source index; cur_vld marks it selected and enabled
module enet_chclk_ctrl_fsm
  import enet_chclk_pkg::*;
#(
  parameter int              NUM_SRC = 2,
  parameter int              SEL_W   = 3,
  parameter int              TO_W    = 16,
  parameter logic [TO_W-1:0] TO_MAX  = TO_W'(DEF_TO_MAX)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic [SEL_W-1:0]   req_sel,
  output logic               req_ready,
  input  logic [NUM_SRC-1:0] ack,
  output logic [NUM_SRC-1:0] clk_sel,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [SEL_W-1:0]   cur_sel,
  output logic               cur_vld
);

  if (NUM_SRC < 2 || NUM_SRC > MAX_SRC || (2 ** SEL_W) < NUM_SRC || TO_W < 1 || TO_MAX == '0)
  begin : g_bad_cfg
    $error("enet_chclk_ctrl_fsm: illegal parameter combination");
  end

  chclk_state_t       state, state_nxt;
  logic [SEL_W-1:0]   tgt, tgt_nxt, cur_sel_nxt;
  logic [NUM_SRC-1:0] clk_sel_nxt, tgt_mask, cur_mask;
  logic               cur_vld_nxt, done_nxt, err_nxt, cur_live;

  assign tgt_mask  = NUM_SRC'(onehot(32'(tgt)));
  assign cur_mask  = NUM_SRC'(onehot(32'(cur_sel)));
  assign cur_live  = |(ack & cur_mask);
  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

`ifdef ENET_CHCLK_CTRL_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt, to_cnt_nxt;
  logic            to_hit;
  // to_hit means this cycle's increment brings the count to TO_MAX.
  assign to_hit = (to_cnt == TO_MAX - TO_W'(1));
`endif

  always_comb begin
    state_nxt   = state;
    tgt_nxt     = tgt;
    clk_sel_nxt = clk_sel;
    cur_sel_nxt = cur_sel;
    cur_vld_nxt = cur_vld;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
`ifdef ENET_CHCLK_CTRL_TIMEOUT_EN
    to_cnt_nxt  = to_cnt;
`endif
    case (state)
      ST_IDLE: begin
        // Active path dropped its enable (path reset): no longer valid,
        // but leave its select line alone.
        if (cur_vld && !cur_live) cur_vld_nxt = 1'b0;
        if (req_valid) begin
          tgt_nxt = req_sel;
          if (int'(req_sel) >= NUM_SRC) begin
            err_nxt = 1'b1;
          end else if (cur_vld && cur_live && req_sel == cur_sel) begin
            done_nxt = 1'b1;
          end else begin
            clk_sel_nxt = '0;
            cur_vld_nxt = 1'b0;
            state_nxt   = ST_OFF;
          end
        end
      end
      ST_OFF: begin
        // Break: every path must report disabled before any new select.
        if (ack == '0) begin
          clk_sel_nxt = tgt_mask;
          state_nxt   = ST_ON;
        end
      end
      ST_ON: begin
        if (ack == tgt_mask) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        cur_sel_nxt = tgt;
        cur_vld_nxt = 1'b1;
        done_nxt    = 1'b1;
        state_nxt   = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
`ifdef ENET_CHCLK_CTRL_TIMEOUT_EN
    if (state == ST_OFF || state == ST_ON) begin
      to_cnt_nxt = to_cnt + TO_W'(1);
      if (state_nxt == state && to_hit) begin
        clk_sel_nxt = '0;
        cur_vld_nxt = 1'b0;
        err_nxt     = 1'b1;
        state_nxt   = ST_IDLE;
      end
    end
    if (state_nxt != state && (state_nxt == ST_OFF || state_nxt == ST_ON)) to_cnt_nxt = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      tgt     <= '0;
      clk_sel <= '0;
      cur_sel <= '0;
      cur_vld <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
`ifdef ENET_CHCLK_CTRL_TIMEOUT_EN
      to_cnt  <= '0;
`endif
    end else begin
      state   <= state_nxt;
      tgt     <= tgt_nxt;
      clk_sel <= clk_sel_nxt;
      cur_sel <= cur_sel_nxt;
      cur_vld <= cur_vld_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
`ifdef ENET_CHCLK_CTRL_TIMEOUT_EN
      to_cnt  <= to_cnt_nxt;
`endif
    end
  end

endmodule

// File: rtl/general_sync.sv
// rtl/general_sync.sv - multi-stage flop synchronizer for asynchronous level signals
//
// Ports:
//   clk    destination clock
//   rst_n  asynchronous active-low reset, every stage loads RST_VAL
//   d      asynchronous input bits
//   q      synchronized output, CHAIN_LV cycles of latency
module general_sync #(
  parameter int   WIDTH    = 1,
  parameter int   CHAIN_LV = 2,
  parameter logic RST_VAL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [CHAIN_LV];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHAIN_LV; i++) stage[i] <= {WIDTH{RST_VAL}};
    end else begin
      stage[0] <= d;
      for (int i = 1; i < CHAIN_LV; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[CHAIN_LV-1];

endmodule

// File: rtl/enet_chclk_ctrl.sv
// rtl/enet_chclk_ctrl.sv - ENET glitch-free clock switch control-domain initiator
//
// Optional feature macro: ENET_CHCLK_CTRL_TIMEOUT_EN (OFF/ON waits abort after TO_MAX cycles)
//
// Ports:
//   clk, rst_n   control clock, asynchronous active-low reset
//   req_valid    switch request, req_sel = requested source index, req_ready = IDLE
//   clk_sel      one-hot (or zero) select to each per-source gating path
//   clk_ena_fb   clk_ena returned from each path, asynchronous to clk
//   busy         switch in progress
//   done / err   one-cycle success / failure pulses
//   cur_sel      active source index, cur_vld = selected and enabled
module enet_chclk_ctrl
  import enet_chclk_pkg::*;
#(
  parameter int              NUM_SRC = 2,
  parameter int              SEL_W   = 3,
  parameter int              SYNC_LV = DEF_SYNC_LV,
  parameter int              TO_W    = 16,
  parameter logic [TO_W-1:0] TO_MAX  = TO_W'(DEF_TO_MAX)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic [SEL_W-1:0]   req_sel,
  output logic               req_ready,
  output logic [NUM_SRC-1:0] clk_sel,
  input  logic [NUM_SRC-1:0] clk_ena_fb,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [SEL_W-1:0]   cur_sel,
  output logic               cur_vld
);

  logic [NUM_SRC-1:0] ack;

  general_sync #(
    .WIDTH   (NUM_SRC),
    .CHAIN_LV(SYNC_LV),
    .RST_VAL (1'b0)
  ) u_ack_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (clk_ena_fb),
    .q    (ack)
  );

  enet_chclk_ctrl_fsm #(
    .NUM_SRC(NUM_SRC),
    .SEL_W  (SEL_W),
    .TO_W   (TO_W),
    .TO_MAX (TO_MAX)
  ) u_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_sel  (req_sel),
    .req_ready(req_ready),
    .ack      (ack),
    .clk_sel  (clk_sel),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cur_sel  (cur_sel),
    .cur_vld  (cur_vld)
  );

endmodule
